// File: rtl/dexpander.sv
`default_nettype none
// ============================================================================
//  Module      : dexpander
//  Description : Dynamic-range expander for an 8-bit signed sample stream.
//                Tracks a peak envelope of |x| and applies upward gain
//                (never below unity) once the envelope rises above THRESHOLD.
//                Three-stage pipeline: capture/abs, envelope+gain, multiply+sat.
//  Revision    : 1.0  initial release
// ============================================================================
module dexpander #(
   parameter int THRESHOLD     = 32,
   parameter int SLOPE         = 8,
   parameter int GAIN_MAX      = 192,
   parameter int ATTACK_SHIFT  = 1,
   parameter int RELEASE_SHIFT = 4,
   parameter int ENV_FRAC      = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   input  logic signed [7:0] i_data,
   input  logic              i_bypass,
   output logic              o_valid,
   output logic signed [7:0] o_data
);

   localparam int ENV_W = 8 + ENV_FRAC;
   localparam logic [7:0] UNITY = 8'd64;

   // stage 1 registers
   logic signed [7:0] x1;
   logic [6:0]        a1;
   logic              v1;
   logic              b1;

   // stage 2 registers
   logic [ENV_W-1:0]  env;
   logic [7:0]        gain;
   logic signed [7:0] x2;
   logic              v2;

   // stage 1 combinational magnitude; -128 has no positive twin, so clamp to 127
   logic [7:0] neg_data;
   logic [6:0] abs_data;

   // stage 2 combinational envelope and gain
   logic [ENV_W-1:0] tgt;
   logic [ENV_W-1:0] env_next;
   logic [7:0]       env_int;
   logic [15:0]      excess;
   logic [15:0]      boost;
   logic [15:0]      gain_raw;
   logic [7:0]       gain_next;

   // stage 3 combinational product and saturation
   logic signed [16:0] prod;
   logic signed [16:0] scaled;
   logic signed [7:0]  sat_data;

   // magnitude of the incoming sample with -128 folded onto 127
   always_comb begin
      neg_data = 8'(-i_data);
      abs_data = i_data[6:0];
      if (i_data[7]) begin
         abs_data = (i_data == 8'sh80) ? 7'd127 : neg_data[6:0];
      end
   end

   // envelope follower: fast attack toward a louder target, slow release otherwise
   always_comb begin
      tgt = {1'b0, a1, {ENV_FRAC{1'b0}}};
      if (tgt > env) begin
         env_next = env + ((tgt - env) >> ATTACK_SHIFT);
      end else begin
         env_next = env - ((env - tgt) >> RELEASE_SHIFT);
      end
      env_int = env_next[ENV_FRAC+7:ENV_FRAC];
   end

   // gain law: unity up to THRESHOLD, then linear rise clamped at GAIN_MAX
   always_comb begin
      excess    = 16'(env_int) - 16'(THRESHOLD);
      boost     = 16'(excess * 16'(SLOPE)) >> 4;
      gain_raw  = 16'(UNITY) + boost;
      gain_next = UNITY;
      if (!b1 && (16'(env_int) > 16'(THRESHOLD))) begin
         gain_next = (gain_raw > 16'(GAIN_MAX)) ? 8'(GAIN_MAX) : gain_raw[7:0];
      end
   end

   // apply Q2.6 gain, floor-shift back to integer, saturate to 8 bits
   always_comb begin
      prod   = 17'(x2) * 17'($signed({1'b0, gain}));
      scaled = prod >>> 6;
      if (scaled > 17'sd127) begin
         sat_data = 8'sd127;
      end else if (scaled < -17'sd128) begin
         sat_data = -8'sd128;
      end else begin
         sat_data = scaled[7:0];
      end
   end

   // stage 1: capture sample, magnitude, and qualifiers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         x1 <= '0;
         a1 <= '0;
         v1 <= 1'b0;
         b1 <= 1'b0;
      end else begin
         x1 <= i_data;
         a1 <= abs_data;
         v1 <= i_valid;
         b1 <= i_bypass;
      end
   end

   // stage 2: envelope and gain advance only on valid samples
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         env  <= '0;
         gain <= '0;
         x2   <= '0;
         v2   <= 1'b0;
      end else begin
         if (v1) begin
            env  <= env_next;
            gain <= gain_next;
         end
         x2 <= x1;
         v2 <= v1;
      end
   end

   // stage 3: output register; data holds across idle cycles
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         o_valid <= v2;
         if (v2) begin
            o_data <= sat_data;
         end
      end
   end

endmodule
`default_nettype wire
